// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32IM core: operand forwarding, operand select and hazard stall.
// Build option EX_FORWARD_EN: defined = EX/MEM + MEM/WB forwarding with load-use stall; undefined = full interlock.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_data1_i,
  input  logic [XLEN-1:0]       id_data2_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [SEL_W-1:0]      id_select_i,
  input  logic [1:0]            id_opsel_i,
  input  logic [2:0]            id_ctrl_i,
  input  logic                  flush_i,
  input  logic                  stall_in_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_we_i,
  input  logic [XLEN-1:0]       exmem_result_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_we_i,
  input  logic [XLEN-1:0]       memwb_result_i,
  output logic                  hazard_stall_o,
  output logic [XLEN-1:0]       alu_data1_o,
  output logic [XLEN-1:0]       alu_data2_o,
  output logic [SEL_W-1:0]      alu_select_o,
  output logic [XLEN-1:0]       ex_store_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [2:0]            ex_ctrl_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic                  ex_valid_o
);

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  logic                  ex_valid_q;
  logic [XLEN-1:0]       pc_q, data1_q, data2_q, imm_q;
  logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [SEL_W-1:0]      select_q;
  logic [1:0]            opsel_q;
  logic [2:0]            ctrl_q;

  logic                  hazard;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;

  function automatic logic writer_hit(input logic [REG_ADDR_W-1:0] rs,
                                      input logic                  we,
                                      input logic [REG_ADDR_W-1:0] rd);
    return we && (rd == rs) && (rs != X0);
  endfunction

`ifdef EX_FORWARD_EN
  logic load_in_ex;

  assign load_in_ex = ex_valid_q && ctrl_q[1] && (rd_q != X0);
  assign hazard     = id_valid_i && load_in_ex && ((id_rs1_i == rd_q) || (id_rs2_i == rd_q))
                      && !flush_i && !reset_i;

  // EX/MEM is the younger result, so it wins over MEM/WB
  assign fwd_rs1 = writer_hit(rs1_q, exmem_we_i, exmem_rd_i) ? exmem_result_i :
                   writer_hit(rs1_q, memwb_we_i, memwb_rd_i) ? memwb_result_i : data1_q;
  assign fwd_rs2 = writer_hit(rs2_q, exmem_we_i, exmem_rd_i) ? exmem_result_i :
                   writer_hit(rs2_q, memwb_we_i, memwb_rd_i) ? memwb_result_i : data2_q;
`else
  logic ex_writes, rs1_hit, rs2_hit;
  logic unused_fwd;

  // Without forwarding, any in-flight writer of a source register blocks issue
  assign ex_writes = ex_valid_q && ctrl_q[2];
  assign rs1_hit   = writer_hit(id_rs1_i, ex_writes, rd_q) ||
                     writer_hit(id_rs1_i, exmem_we_i, exmem_rd_i) ||
                     writer_hit(id_rs1_i, memwb_we_i, memwb_rd_i);
  assign rs2_hit   = writer_hit(id_rs2_i, ex_writes, rd_q) ||
                     writer_hit(id_rs2_i, exmem_we_i, exmem_rd_i) ||
                     writer_hit(id_rs2_i, memwb_we_i, memwb_rd_i);
  assign hazard    = id_valid_i && (rs1_hit || rs2_hit) && !flush_i && !reset_i;

  assign fwd_rs1    = data1_q;
  assign fwd_rs2    = data2_q;
  assign unused_fwd = ^{exmem_result_i, memwb_result_i, rs1_q, rs2_q};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      select_q   <= '0;
      opsel_q    <= '0;
      ctrl_q     <= '0;
    end else if (flush_i || (!stall_in_i && hazard)) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      select_q   <= '0;
    end else if (!stall_in_i) begin
      ex_valid_q <= id_valid_i;
      pc_q       <= id_pc_i;
      data1_q    <= id_data1_i;
      data2_q    <= id_data2_i;
      imm_q      <= id_imm_i;
      rs1_q      <= id_rs1_i;
      rs2_q      <= id_rs2_i;
      rd_q       <= id_rd_i;
      select_q   <= id_select_i;
      opsel_q    <= id_opsel_i;
      ctrl_q     <= id_valid_i ? id_ctrl_i : 3'b000;
    end
  end

  assign hazard_stall_o  = hazard;
  assign alu_data1_o     = ex_valid_q ? (opsel_q[0] ? pc_q : fwd_rs1) : '0;
  assign alu_data2_o     = ex_valid_q ? (opsel_q[1] ? imm_q : fwd_rs2) : '0;
  assign ex_store_data_o = ex_valid_q ? fwd_rs2 : '0;
  assign alu_select_o    = select_q;
  assign ex_rd_o         = rd_q;
  assign ex_ctrl_o       = ctrl_q;
  assign ex_pc_o         = pc_q;
  assign ex_valid_o      = ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: vector table with scoreboard plus hand-written hazard/stall sequences.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        reset_i, id_valid_i, flush_i, stall_in_i, exmem_we_i, memwb_we_i;
  logic [31:0] id_pc_i, id_data1_i, id_data2_i, id_imm_i, exmem_result_i, memwb_result_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, exmem_rd_i, memwb_rd_i;
  logic [5:0]  id_select_i;
  logic [1:0]  id_opsel_i;
  logic [2:0]  id_ctrl_i;
  logic        hazard_stall_o, ex_valid_o;
  logic [31:0] alu_data1_o, alu_data2_o, ex_store_data_o, ex_pc_o;
  logic [5:0]  alu_select_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_ctrl_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_data1_i(id_data1_i), .id_data2_i(id_data2_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_select_i(id_select_i),
    .id_opsel_i(id_opsel_i), .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .stall_in_i(stall_in_i),
    .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_we_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_we_i), .memwb_result_i(memwb_result_i),
    .hazard_stall_o(hazard_stall_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_select_o(alu_select_o), .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
    .ex_ctrl_o(ex_ctrl_o), .ex_pc_o(ex_pc_o), .ex_valid_o(ex_valid_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  sel;
    logic [1:0]  opsel;
    logic [2:0]  ctrl;
    logic        ev;
    logic [31:0] a1, a2, st;
    logic [2:0]  ectrl;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [31:0] a1, a2, st, pc;
    logic [2:0]  ctrl;
    logic [5:0]  sel;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic v, input logic [31:0] pc, d1, d2, imm,
                              input logic [4:0] rs1, rs2, rd, input logic [5:0] sel,
                              input logic [1:0] opsel, input logic [2:0] ctrl,
                              input logic ev, input logic [31:0] a1, a2, st,
                              input logic [2:0] ectrl);
    vec_t r;
    r.v = v; r.pc = pc; r.d1 = d1; r.d2 = d2; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.sel = sel; r.opsel = opsel; r.ctrl = ctrl;
    r.ev = ev; r.a1 = a1; r.a2 = a2; r.st = st; r.ectrl = ectrl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    id_valid_i = v.v; id_pc_i = v.pc; id_data1_i = v.d1; id_data2_i = v.d2; id_imm_i = v.imm;
    id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_rd_i = v.rd; id_select_i = v.sel;
    id_opsel_i = v.opsel; id_ctrl_i = v.ctrl;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic writers(input logic [4:0] xr, input logic xw, input logic [31:0] xd,
                         input logic [4:0] mr, input logic mw, input logic [31:0] md);
    exmem_rd_i = xr; exmem_we_i = xw; exmem_result_i = xd;
    memwb_rd_i = mr; memwb_we_i = mw; memwb_result_i = md;
  endtask

  initial begin
    exp_t e;
    // rd/rs picked so no vector collides with the previous instruction's writer
    vecs[0] = mk(1, 32'h100, 32'h11, 32'h55, 32'hFFFFF800, 1, 2, 10, 6'h03, 2'b11, 3'b100,
                 1, 32'h100, 32'hFFFFF800, 32'h55, 3'b100);
    vecs[1] = mk(1, 32'h104, 32'hAAAA0000, 32'h1234, 32'h8, 3, 4, 11, 6'h2A, 2'b00, 3'b100,
                 1, 32'hAAAA0000, 32'h1234, 32'h1234, 3'b100);
    vecs[2] = mk(1, 32'h108, 32'h7, 32'h9, 32'h20, 5, 6, 0, 6'h3F, 2'b10, 3'b001,
                 1, 32'h7, 32'h20, 32'h9, 3'b001);
    vecs[3] = mk(0, 32'h10C, 32'h99, 32'h77, 32'h1, 7, 8, 12, 6'h05, 2'b01, 3'b110,
                 0, 32'h0, 32'h0, 32'h0, 3'b000);
    vecs[4] = mk(1, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h4, 0, 0, 13, 6'h10, 2'b01, 3'b110,
                 1, 32'h200, 32'h0, 32'h0, 3'b110);
    vecs[5] = mk(1, 32'h204, 32'h31, 32'h32, 32'h33, 14, 15, 16, 6'h11, 2'b00, 3'b010,
                 1, 32'h31, 32'h32, 32'h32, 3'b010);

    // Reset with busy inputs; rs1 matching EX/MEM would stall if reset did not gate it
    reset_i = 1; flush_i = 0; stall_in_i = 0;
    drive(mk(1, 32'hABC, 32'h1, 32'h2, 32'h3, 1, 2, 3, 6'h3F, 2'b00, 3'b111, 0, 0, 0, 0, 0));
    writers(1, 1, 32'h22, 2, 1, 32'h33);
    tick();
    tick();
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_ctrl", ex_ctrl_o, 0);
    chk("rst_sel", alu_select_o, 0);
    chk("rst_a1", alu_data1_o, 0);
    chk("rst_a2", alu_data2_o, 0);
    chk("rst_st", ex_store_data_o, 0);
    chk("rst_hazard", hazard_stall_o, 0);
    idle();
    writers(0, 0, 0, 0, 0, 0);
    reset_i = 0;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      e.ev = vecs[i].ev; e.a1 = vecs[i].a1; e.a2 = vecs[i].a2; e.st = vecs[i].st;
      e.pc = vecs[i].pc; e.ctrl = vecs[i].ectrl; e.sel = vecs[i].sel; e.rd = vecs[i].rd;
      sb_q.push_back(e);
      #1 chk($sformatf("v%0d_hazard", i), hazard_stall_o, 0);
      tick();
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL v%0d_sb: got empty queue expected entry", i);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_valid", i), ex_valid_o, e.ev);
        chk($sformatf("v%0d_a1", i), alu_data1_o, e.a1);
        chk($sformatf("v%0d_a2", i), alu_data2_o, e.a2);
        chk($sformatf("v%0d_st", i), ex_store_data_o, e.st);
        chk($sformatf("v%0d_ctrl", i), ex_ctrl_o, e.ctrl);
        chk($sformatf("v%0d_sel", i), alu_select_o, e.sel);
        chk($sformatf("v%0d_rd", i), ex_rd_o, e.rd);
        chk($sformatf("v%0d_pc", i), ex_pc_o, e.pc);
      end
    end

    // STALL_IN holds vector 5 while ID changes underneath
    stall_in_i = 1;
    drive(mk(1, 32'h900, 32'h1, 32'h2, 32'h3, 9, 9, 9, 6'h01, 2'b11, 3'b111, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), ex_valid_o, 1);
      chk($sformatf("stall%0d_a1", i), alu_data1_o, 32'h31);
      chk($sformatf("stall%0d_a2", i), alu_data2_o, 32'h32);
      chk($sformatf("stall%0d_pc", i), ex_pc_o, 32'h204);
      chk($sformatf("stall%0d_sel", i), alu_select_o, 6'h11);
    end
    flush_i = 1;
    tick();
    chk("flush_stall_valid", ex_valid_o, 0);
    chk("flush_stall_ctrl", ex_ctrl_o, 0);
    chk("flush_stall_sel", alu_select_o, 0);
    chk("flush_stall_a1", alu_data1_o, 0);
    flush_i = 0; stall_in_i = 0;
    idle();
    tick();

`ifdef EX_FORWARD_EN
    drive(mk(1, 32'h400, 32'h11, 32'h0, 32'h0, 5, 0, 21, 6'h02, 2'b00, 3'b100, 0, 0, 0, 0, 0));
    tick();
    idle();
    writers(5, 1, 32'h22, 5, 1, 32'h33);
    #1 chk("fwd_exmem", alu_data1_o, 32'h22);
    exmem_we_i = 0;
    #1 chk("fwd_memwb", alu_data1_o, 32'h33);
    drive(mk(1, 32'h404, 32'h0, 32'h0, 32'h0, 0, 0, 0, 6'h02, 2'b00, 3'b100, 0, 0, 0, 0, 0));
    writers(0, 1, 32'h22, 0, 1, 32'h33);
    tick();
    chk("fwd_x0", alu_data1_o, 32'h0);

    writers(0, 0, 0, 0, 0, 0);
    drive(mk(1, 32'h408, 32'h0, 32'h0, 32'h0, 1, 2, 7, 6'h03, 2'b00, 3'b110, 0, 0, 0, 0, 0));
    tick();
    drive(mk(1, 32'h40C, 32'h0, 32'h1, 32'h0, 0, 7, 22, 6'h04, 2'b00, 3'b100, 0, 0, 0, 0, 0));
    #1 chk("loaduse_hazard", hazard_stall_o, 1);
    tick();
    chk("loaduse_bubble", ex_valid_o, 0);
    chk("loaduse_once", hazard_stall_o, 0);
    writers(0, 0, 0, 7, 1, 32'hDEAD);
    tick();
    chk("loaduse_capture", ex_valid_o, 1);
    chk("loaduse_fwd", alu_data2_o, 32'hDEAD);
`else
    drive(mk(1, 32'h300, 32'h44, 32'h66, 32'h0, 3, 0, 20, 6'h01, 2'b00, 3'b100, 0, 0, 0, 0, 0));
    writers(3, 1, 32'h22, 0, 0, 0);
    #1 chk("hz_exmem", hazard_stall_o, 1);
    tick();
    chk("hz_bubble", ex_valid_o, 0);
    chk("hz_exmem_hold", hazard_stall_o, 1);
    tick();
    chk("hz_bubble2", ex_valid_o, 0);
    exmem_we_i = 0;
    #1 chk("hz_exmem_clear", hazard_stall_o, 0);
    tick();
    chk("hz_capture", ex_valid_o, 1);
    chk("hz_capture_a1", alu_data1_o, 32'h44);
    idle();
    writers(3, 1, 32'h22, 3, 1, 32'h33);
    #1 chk("no_fwd_a1", alu_data1_o, 32'h44);

    writers(0, 0, 0, 0, 0, 0);
    drive(mk(1, 32'h304, 32'h0, 32'h0, 32'h0, 0, 20, 23, 6'h01, 2'b00, 3'b100, 0, 0, 0, 0, 0));
    #1 chk("hz_ex_writer", hazard_stall_o, 1);
    flush_i = 1;
    #1 chk("hz_flush_gate", hazard_stall_o, 0);
    flush_i = 0;
    id_rs2_i = 9;
    writers(0, 0, 0, 9, 1, 32'h33);
    #1 chk("hz_memwb", hazard_stall_o, 1);
    id_rs2_i = 0;
    memwb_rd_i = 0;
    #1 chk("hz_x0", hazard_stall_o, 0);
    writers(0, 0, 0, 0, 0, 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
